// File: rtl/vga_pkg.sv
// Shared constants for the VGA line buffer slice.
// Holds the 640x480@60 timing limits, pixel and counter widths, and the
// per-bank state encoding used by the line buffer.
package vga_pkg;

    localparam int unsigned H_VIS = 640;  // visible pixels per line
    localparam int unsigned H_TOT = 800;  // clocks per line
    localparam int unsigned V_VIS = 480;  // visible lines
    localparam int unsigned V_TOT = 525;  // lines per frame

    localparam int unsigned PIX_W = 9;    // {R[2:0], G[2:0], B[2:0]}
    localparam int unsigned CNT_W = 10;   // timing counter width

    typedef logic [1:0] bank_state_t;

    localparam bank_state_t BANK_EMPTY   = 2'd0;
    localparam bank_state_t BANK_FILLING = 2'd1;
    localparam bank_state_t BANK_FULL    = 2'd2;
    localparam bank_state_t BANK_READING = 2'd3;

endpackage

// File: rtl/vga_line_ram.sv
// Simple dual-port line RAM: one write port, one synchronous read port.
// Contents are not reset. Shaped to map onto iCE40 EBR.
//   clk   : clock
//   we    : write enable, waddr/wdata : write address/data
//   re    : read enable,  raddr       : read address
//   rdata : registered read data (holds when re is low)
module vga_line_ram #(
    parameter int unsigned DEPTH = 640,
    parameter int unsigned WIDTH = 9,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/vga_line_buffer.sv
// Ping-pong line buffer between a pixel producer stream and the VGA pins.
// The producer fills one bank while the other is displayed in step with the
// timing counters. Colour appears one clock after its h_count/v_count.
//   clk, rst           : pixel clock, asynchronous active-high reset
//   h_count, v_count   : timing generator counters
//   in_valid/in_ready  : producer handshake, in_pixel data, in_sof frame start
//   R, G, B            : 3-bit colour outputs
//   underrun           : pulse, visible line began with no full bank
//   sync_err           : pulse, in_sof accepted mid-line
module vga_line_buffer #(
    parameter int unsigned H_VIS = vga_pkg::H_VIS,
    parameter int unsigned H_TOT = vga_pkg::H_TOT,
    parameter int unsigned V_VIS = vga_pkg::V_VIS,
    parameter int unsigned V_TOT = vga_pkg::V_TOT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [9:0] h_count,
    input  logic [9:0] v_count,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [8:0] in_pixel,
    input  logic       in_sof,
    output logic [2:0] R,
    output logic [2:0] G,
    output logic [2:0] B,
    output logic       underrun,
    output logic       sync_err
);

    import vga_pkg::*;

    localparam int unsigned RAM_AW = $clog2(H_VIS);

    localparam logic [CNT_W-1:0] H_VIS_C    = CNT_W'(H_VIS);
    localparam logic [CNT_W-1:0] H_LAST     = CNT_W'(H_TOT - 1);
    localparam logic [CNT_W-1:0] V_VIS_C    = CNT_W'(V_VIS);
    localparam logic [CNT_W-1:0] V_VIS_LAST = CNT_W'(V_VIS - 1);
    localparam logic [CNT_W-1:0] V_LAST     = CNT_W'(V_TOT - 1);
    localparam logic [CNT_W-1:0] X_LAST     = CNT_W'(H_VIS - 1);

    bank_state_t [1:0] bank_q, bank_d;
    logic [CNT_W-1:0]  wr_x_q, wr_x_d;
    logic              wr_bank_q, wr_bank_d;
    logic              rd_valid_q, rd_valid_d;
    logic              rd_bank_q, rd_bank_d;

    logic              show_q, sel_q;
    logic              underrun_q, sync_err_q;

    logic              accept, sof_resync;
    logic              line_bnd, frame_end, visible;
    logic              next_bank, next_full;
    logic [1:0]        we, re;
    logic [RAM_AW-1:0] waddr;
    logic [1:0][PIX_W-1:0] rdata;
    logic [PIX_W-1:0]  pix;

    assign in_ready   = (bank_q[wr_bank_q] == BANK_EMPTY) ||
                        (bank_q[wr_bank_q] == BANK_FILLING);
    assign accept     = in_valid & in_ready;
    assign sof_resync = accept & in_sof & (wr_x_q != '0);

    // Boundary just before each visible line; frame_end only retires the
    // last visible line's bank.
    assign line_bnd  = (h_count == H_LAST) &&
                       ((v_count == V_LAST) || (v_count < V_VIS_LAST));
    assign frame_end = (h_count == H_LAST) && (v_count == V_VIS_LAST);
    assign visible   = (h_count < H_VIS_C) && (v_count < V_VIS_C);

    // Oldest complete line: if both banks are FULL the writer has wrapped
    // onto the older one, otherwise the only candidate is the other bank.
    // When the writer bank is READING this also yields the non-read bank.
    assign next_bank = (bank_q[wr_bank_q] == BANK_FULL) ? wr_bank_q : ~wr_bank_q;
    assign next_full = (bank_q[next_bank] == BANK_FULL);

    always_comb begin
        bank_d     = bank_q;
        wr_x_d     = wr_x_q;
        wr_bank_d  = wr_bank_q;
        rd_valid_d = rd_valid_q;
        rd_bank_d  = rd_bank_q;

        if (accept) begin
            if (sof_resync) begin
                // Drop the partial line; the sof pixel lands at index 0.
                bank_d[wr_bank_q] = BANK_FILLING;
                wr_x_d            = CNT_W'(1);
            end else if (wr_x_q == X_LAST) begin
                bank_d[wr_bank_q] = BANK_FULL;
                wr_x_d            = '0;
                wr_bank_d         = ~wr_bank_q;
            end else begin
                bank_d[wr_bank_q] = BANK_FILLING;
                wr_x_d            = wr_x_q + 1'b1;
            end
        end

        // Uses pre-update state, so a line finishing on this very cycle
        // is picked up at the next boundary. Banks touched here never
        // coincide with the writer's bank on an accepting cycle.
        if (line_bnd || frame_end) begin
            if (rd_valid_q) begin
                bank_d[rd_bank_q] = BANK_EMPTY;
            end
            rd_valid_d = 1'b0;
            if (line_bnd && next_full) begin
                bank_d[next_bank] = BANK_READING;
                rd_valid_d        = 1'b1;
                rd_bank_d         = next_bank;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bank_q     <= {BANK_EMPTY, BANK_EMPTY};
            wr_x_q     <= '0;
            wr_bank_q  <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_bank_q  <= 1'b0;
            show_q     <= 1'b0;
            sel_q      <= 1'b0;
            underrun_q <= 1'b0;
            sync_err_q <= 1'b0;
        end else begin
            bank_q     <= bank_d;
            wr_x_q     <= wr_x_d;
            wr_bank_q  <= wr_bank_d;
            rd_valid_q <= rd_valid_d;
            rd_bank_q  <= rd_bank_d;
            show_q     <= visible & rd_valid_q;
            sel_q      <= rd_bank_q;
            underrun_q <= line_bnd & ~next_full;
            sync_err_q <= sof_resync;
        end
    end

    always_comb begin
        we    = 2'b00;
        re    = 2'b00;
        waddr = sof_resync ? '0 : wr_x_q[RAM_AW-1:0];
        we[wr_bank_q] = accept;
        re[rd_bank_q] = visible & rd_valid_q;
    end

    vga_line_ram #(
        .DEPTH (H_VIS),
        .WIDTH (PIX_W),
        .AW    (RAM_AW)
    ) u_bank0 (
        .clk   (clk),
        .we    (we[0]),
        .waddr (waddr),
        .wdata (in_pixel),
        .re    (re[0]),
        .raddr (h_count[RAM_AW-1:0]),
        .rdata (rdata[0])
    );

    vga_line_ram #(
        .DEPTH (H_VIS),
        .WIDTH (PIX_W),
        .AW    (RAM_AW)
    ) u_bank1 (
        .clk   (clk),
        .we    (we[1]),
        .waddr (waddr),
        .wdata (in_pixel),
        .re    (re[1]),
        .raddr (h_count[RAM_AW-1:0]),
        .rdata (rdata[1])
    );

    // The EBR output register is the pixel register; show_q blanks it
    // outside the visible area and on underrun lines.
    assign pix      = show_q ? rdata[sel_q] : '0;
    assign R        = pix[8:6];
    assign G        = pix[5:3];
    assign B        = pix[2:0];
    assign underrun = underrun_q;
    assign sync_err = sync_err_q;

endmodule

// File: tb/tb_vga_line_buffer.sv
module tb_vga_line_buffer;

    localparam int HV = 32;
    localparam int HT = 40;
    localparam int VV = 8;
    localparam int VT = 11;

    logic       clk = 1'b0;
    logic       rst;
    logic [9:0] h_count, v_count;
    logic       in_valid, in_ready, in_sof;
    logic [8:0] in_pixel;
    logic [2:0] R, G, B;
    logic       underrun, sync_err;

    vga_line_buffer #(
        .H_VIS (HV),
        .H_TOT (HT),
        .V_VIS (VV),
        .V_TOT (VT)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .h_count  (h_count),
        .v_count  (v_count),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_pixel (in_pixel),
        .in_sof   (in_sof),
        .R        (R),
        .G        (G),
        .B        (B),
        .underrun (underrun),
        .sync_err (sync_err)
    );

    always #20 clk = ~clk;

    typedef struct packed {
        logic [8:0] rgb;
        logic       und;
        logic       serr;
    } exp_t;

    typedef struct packed {
        logic [8:0] pix;
        logic       sof;
    } src_t;

    typedef struct {
        logic [8:0] pix;
        logic [2:0] r;
        logic [2:0] g;
        logic [2:0] b;
    } vec_t;

    int n_checks = 0;
    int n_errors = 0;

    exp_t            exp_q[$];
    src_t            src_q[$];
    logic [9*HV-1:0] full_q[$];
    logic [8:0]      shown_q[$];
    logic [9*HV-1:0] m_wbuf, m_line;
    int              m_wx;
    bit              m_disp;

    int hc, vc, ph, pv;
    bit cap_en, saw_not_ready;
    int cnt_und, cnt_serr, cnt_nz;
    vec_t vecs[4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (h=%0d v=%0d)", name, act, expv, hc, vc);
        end
    endtask

    task automatic drive_inputs();
        h_count = hc[9:0];
        v_count = vc[9:0];
        if (src_q.size() > 0) begin
            in_valid = 1'b1;
            in_pixel = src_q[0].pix;
            in_sof   = src_q[0].sof;
        end else begin
            in_valid = 1'b0;
            in_pixel = '0;
            in_sof   = 1'b0;
        end
    endtask

    // One clock: compare at the falling edge, model the coming rising edge,
    // then advance counters and stimulus just after it.
    task automatic cycle();
        exp_t e;
        bit   acc;
        bit   done;
        bit   rdy_exp;
        acc = 1'b0;
        @(negedge clk);
        if (rst) begin
            check("rst_rgb", 32'({R, G, B}), 32'd0);
            check("rst_underrun", 32'(underrun), 32'd0);
            check("rst_sync_err", 32'(sync_err), 32'd0);
            check("rst_in_ready", 32'(in_ready), 32'd1);
            exp_q.delete();
            full_q.delete();
            m_disp = 1'b0;
            m_wx   = 0;
        end else begin
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("rgb", 32'({R, G, B}), 32'(e.rgb));
                check("underrun", 32'(underrun), 32'(e.und));
                check("sync_err", 32'(sync_err), 32'(e.serr));
            end
            if ({R, G, B} != 9'd0) cnt_nz++;
            if (underrun) cnt_und++;
            if (sync_err) cnt_serr++;
            if (cap_en && ph == 0 && pv >= 0 && pv < VV) shown_q.push_back({R, G, B});
            rdy_exp = (full_q.size() + (m_disp ? 1 : 0)) < 2;
            check("in_ready", 32'(in_ready), 32'(rdy_exp));
            if (!in_ready) saw_not_ready = 1'b1;
            acc = in_valid && in_ready;

            e = '0;
            if (hc < HV && vc < VV && m_disp) e.rgb = m_line[hc*9 +: 9];
            done = 1'b0;
            if (acc) begin
                if (in_sof && m_wx != 0) begin
                    e.serr      = 1'b1;
                    m_wbuf[8:0] = in_pixel;
                    m_wx        = 1;
                end else begin
                    m_wbuf[m_wx*9 +: 9] = in_pixel;
                    if (m_wx == HV - 1) begin
                        done = 1'b1;
                        m_wx = 0;
                    end else begin
                        m_wx++;
                    end
                end
            end
            if (hc == HT - 1) begin
                if (vc == VT - 1 || vc < VV - 1) begin
                    m_disp = 1'b0;
                    if (full_q.size() > 0) begin
                        m_line = full_q.pop_front();
                        m_disp = 1'b1;
                    end else begin
                        e.und = 1'b1;
                    end
                end else if (vc == VV - 1) begin
                    m_disp = 1'b0;
                end
            end
            if (done) full_q.push_back(m_wbuf);
            exp_q.push_back(e);
        end
        ph = hc;
        pv = vc;
        @(posedge clk);
        #1;
        if (acc) void'(src_q.pop_front());
        if (hc == HT - 1) begin
            hc = 0;
            vc = (vc == VT - 1) ? 0 : vc + 1;
        end else begin
            hc++;
        end
        drive_inputs();
    endtask

    task automatic wait_until(input int hh, input int vv);
        int n;
        n = 0;
        while (!(hc == hh && vc == vv)) begin
            if (n > HT * VT + 2) begin
                n_checks++;
                n_errors++;
                $display("FAIL wait_until: counters never reached h=%0d v=%0d", hh, vv);
                return;
            end
            cycle();
            n++;
        end
    endtask

    task automatic push_line(input logic [8:0] pix);
        for (int x = 0; x < HV; x++) src_q.push_back({pix, 1'b0});
    endtask

    initial begin
        vecs[0] = '{pix: 9'h1C0, r: 3'd7, g: 3'd0, b: 3'd0};
        vecs[1] = '{pix: 9'h007, r: 3'd0, g: 3'd0, b: 3'd7};
        vecs[2] = '{pix: 9'h038, r: 3'd0, g: 3'd7, b: 3'd0};
        vecs[3] = '{pix: 9'h155, r: 3'd5, g: 3'd2, b: 3'd5};

        rst = 1'b1;
        hc = 0; vc = 0; ph = -1; pv = -1;
        cap_en = 1'b0; saw_not_ready = 1'b0;
        cnt_und = 0; cnt_serr = 0; cnt_nz = 0;
        m_wx = 0; m_disp = 1'b0; m_wbuf = '0; m_line = '0;
        drive_inputs();
        repeat (3) cycle();

        // Release with counters two lines before line 0.
        rst = 1'b0;
        hc = 0; vc = VT - 2; ph = -1; pv = -1;
        for (int i = 0; i < 4; i++) push_line(vecs[i].pix);
        drive_inputs();
        cap_en = 1'b1;
        shown_q.delete();
        wait_until(0, VV);
        cap_en = 1'b0;
        check("frame_lines_captured", 32'(shown_q.size()), 32'(VV));
        for (int i = 0; i < 4; i++) begin
            logic [8:0] s;
            s = (shown_q.size() > 0) ? shown_q.pop_front() : 9'h1FF;
            check("table_r", 32'(s[8:6]), 32'(vecs[i].r));
            check("table_g", 32'(s[5:3]), 32'(vecs[i].g));
            check("table_b", 32'(s[2:0]), 32'(vecs[i].b));
        end
        while (shown_q.size() > 0) check("drained_line_black", 32'(shown_q.pop_front()), 32'd0);
        check("in_ready_dropped", 32'(saw_not_ready), 32'd1);

        // Idle producer: one underrun per visible line, nothing shown.
        wait_until(0, 0);
        cnt_und = 0;
        cnt_nz  = 0;
        repeat (HT * VT) cycle();
        check("idle_underruns", 32'(cnt_und), 32'(VV));
        check("idle_black", 32'(cnt_nz), 32'd0);

        // Pixel value equals x index; the scoreboard checks every position.
        for (int x = 0; x < HV; x++) src_q.push_back({9'(x), 1'b0});
        drive_inputs();
        wait_until(0, 0);

        // Last pixel lands on the boundary cycle before line 0.
        wait_until(HT - HV, VT - 1);
        push_line(9'h0F0);
        drive_inputs();
        cnt_und = 0;
        cap_en  = 1'b1;
        shown_q.delete();
        wait_until(0, 2);
        cap_en = 1'b0;
        check("late_lines_captured", 32'(shown_q.size()), 32'd2);
        if (shown_q.size() == 2) begin
            check("late_line0_black", 32'(shown_q[0]), 32'd0);
            check("late_line1_data", 32'(shown_q[1]), 32'h0F0);
        end
        check("late_underruns", 32'(cnt_und), 32'd1);

        // in_sof mid-line resynchronises the writer.
        wait_until(0, 0);
        for (int x = 0; x < HV / 2; x++) src_q.push_back({9'h011, 1'b0});
        src_q.push_back({9'h1FF, 1'b1});
        for (int x = 1; x < HV; x++) src_q.push_back({9'h022, 1'b0});
        drive_inputs();
        cnt_serr = 0;
        cap_en   = 1'b1;
        shown_q.delete();
        wait_until(0, 3);
        cap_en = 1'b0;
        check("sof_sync_err_pulses", 32'(cnt_serr), 32'd1);
        check("sof_lines_captured", 32'(shown_q.size()), 32'd3);
        if (shown_q.size() == 3) check("sof_pixel_at_x0", 32'(shown_q[2]), 32'h1FF);

        // Reset in the middle of a displayed line.
        wait_until(0, 0);
        for (int i = 0; i < 8; i++) push_line(9'h0AA);
        drive_inputs();
        cap_en = 1'b1;
        shown_q.delete();
        wait_until(HV / 2, 5);
        cap_en = 1'b0;
        check("pre_rst_line5", 32'((shown_q.size() == 6) ? shown_q[5] : 9'h000), 32'h0AA);
        rst = 1'b1;
        src_q.delete();
        drive_inputs();
        repeat (2) cycle();
        rst    = 1'b0;
        cnt_nz = 0;
        repeat (2 * HT * VT) cycle();
        check("no_stale_after_rst", 32'(cnt_nz), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
